// File: rtl/mem_boot_loader.sv
// Streams host words into one of N_MEM memories at auto-incrementing addresses over a
// valid/ready handshake, then holds the processor start level between run_go and run_stop.
module mem_boot_loader #(
   parameter int  DATA_W    = 16,
   parameter int  ADDR_W    = 9,
   parameter int  N_MEM     = 2,
   parameter int  BASE_ADDR = 1,
   localparam int SEL_W     = (N_MEM > 1) ? $clog2(N_MEM) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_go,
   input  logic [SEL_W-1:0]  load_sel,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              run_go,
   input  logic              run_stop,
   output logic [N_MEM-1:0]  mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [ADDR_W:0]   words,
   output logic              load_done,
   output logic              overflow,
   output logic              busy,
   output logic              start
);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} state_e;

   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] TOP_ADDR  = {ADDR_W{1'b1}};
   localparam logic [ADDR_W:0]   WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     words_q, words_d;
   logic                overflow_q, overflow_d;
   logic [N_MEM-1:0]    mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                load_done_q, load_done_d;
   logic                hs;

   assign hs = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         addr_q      <= BASE;
         words_q     <= '0;
         overflow_q  <= 1'b0;
         mem_we_q    <= '0;
         mem_addr_q  <= BASE;
         mem_wdata_q <= '0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         addr_q      <= addr_d;
         words_q     <= words_d;
         overflow_q  <= overflow_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         load_done_q <= load_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      addr_d      = addr_q;
      words_d     = words_q;
      overflow_d  = overflow_q;
      mem_we_d    = '0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      load_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            // An out-of-range select drops the load request entirely.
            if (load_go && (int'(load_sel) < N_MEM)) begin
               state_d    = LOAD;
               sel_d      = load_sel;
               addr_d     = BASE;
               words_d    = '0;
               overflow_d = 1'b0;
            end else if (run_go) begin
               state_d = RUN;
            end
         end
         LOAD: begin
            if (hs) begin
               mem_we_d    = N_MEM'(1) << sel_q;
               mem_addr_d  = addr_q;
               mem_wdata_d = in_data;
               words_d     = (words_q == WORDS_MAX) ? words_q : words_q + 1'b1;
               if (in_last) begin
                  state_d     = IDLE;
                  load_done_d = 1'b1;
               end else if (addr_q == TOP_ADDR) begin
                  state_d    = DRAIN;
                  overflow_d = 1'b1;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (hs && in_last) begin
               state_d     = IDLE;
               load_done_d = 1'b1;
            end
         end
         RUN: begin
            if (run_stop) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      start    = 1'b0;
      case (state_q)
         LOAD, DRAIN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         RUN:     start = 1'b1;
         default: ;
      endcase
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign words     = words_q;
   assign load_done = load_done_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Scoreboard bench for mem_boot_loader: a default instance plus a small 3-memory,
// 8-deep instance for the overflow and out-of-range select cases.
module tb_mem_boot_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, load_go = 1'b0, in_valid = 1'b0, in_last = 1'b0;
   logic        run_go = 1'b0, run_stop = 1'b0;
   logic [1:0]  load_sel = '0;
   logic [15:0] in_data = '0;

   logic [1:0]  mem_we_a;  logic [8:0] mem_addr_a;  logic [15:0] mem_wdata_a;  logic [9:0] words_a;
   logic        in_ready_a, load_done_a, overflow_a, busy_a, start_a;
   logic [2:0]  mem_we_b;  logic [2:0] mem_addr_b;  logic [15:0] mem_wdata_b;  logic [3:0] words_b;
   logic        in_ready_b, load_done_b, overflow_b, busy_b, start_b;

   mem_boot_loader u_dut_a (
      .clk(clk), .rst(rst), .load_go(load_go), .load_sel(load_sel[0]),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
      .run_go(run_go), .run_stop(run_stop), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .words(words_a), .load_done(load_done_a),
      .overflow(overflow_a), .busy(busy_a), .start(start_a));

   // load_sel is only 1 bit wide at N_MEM=2, so the out-of-range select is exercised here.
   mem_boot_loader #(.ADDR_W(3), .N_MEM(3)) u_dut_b (
      .clk(clk), .rst(rst), .load_go(load_go), .load_sel(load_sel),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
      .run_go(run_go), .run_stop(run_stop), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .words(words_b), .load_done(load_done_b),
      .overflow(overflow_b), .busy(busy_b), .start(start_b));

   typedef struct {
      int          sel;
      logic [8:0]  addr;
      logic [15:0] data;
      logic        done;
   } wr_t;

   wr_t sb[$];
   int  n_chk = 0, n_err = 0;
   logic mon_b = 1'b0;

   // Every write on the monitored instance must match the oldest expected write.
   always @(negedge clk) begin
      logic [2:0]  we, exp_we;
      logic [8:0]  ad;
      logic [15:0] wd;
      logic        dn;
      wr_t         e;
      if (mon_b) begin we = mem_we_b; ad = {6'd0, mem_addr_b}; wd = mem_wdata_b; dn = load_done_b; end
      else begin we = {1'b0, mem_we_a}; ad = mem_addr_a; wd = mem_wdata_a; dn = load_done_a; end
      if (we != 3'd0) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write we=%b addr=%0d data=%0d", we, ad, wd);
         end else begin
            e = sb.pop_front();
            exp_we = 3'(1) << e.sel;
            if (we !== exp_we || ad !== e.addr || wd !== e.data || dn !== e.done) begin
               n_err++;
               $display("FAIL sb_write got we=%b addr=%0d data=%0d done=%b exp we=%b addr=%0d data=%0d done=%b",
                        we, ad, wd, dn, exp_we, e.addr, e.data, e.done);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic push(input int sel, input int addr, input logic [15:0] data, input logic done);
      wr_t e;
      e.sel = sel; e.addr = 9'(addr); e.data = data; e.done = done;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1; load_go = 1'b0; in_valid = 1'b0; in_last = 1'b0; run_go = 1'b0; run_stop = 1'b0;
      step();
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; step(); step();
      n_chk++; if (in_ready_a !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%b exp=0", in_ready_a); end
      n_chk++; if (mem_we_a !== 2'b00) begin n_err++; $display("FAIL rst_mem_we got=%b exp=00", mem_we_a); end
      n_chk++; if ({load_done_a, overflow_a, busy_a, start_a} !== 4'b0000) begin n_err++; $display("FAIL rst_flags got=%b exp=0000", {load_done_a, overflow_a, busy_a, start_a}); end
      n_chk++; if (mem_addr_a !== 9'd1) begin n_err++; $display("FAIL rst_mem_addr got=%0d exp=1", mem_addr_a); end
      n_chk++; if (mem_wdata_a !== 16'd0) begin n_err++; $display("FAIL rst_mem_wdata got=%0d exp=0", mem_wdata_a); end
      n_chk++; if (words_a !== 10'd0) begin n_err++; $display("FAIL rst_words got=%0d exp=0", words_a); end
      rst = 1'b0;
   endtask

   task automatic test_load3();
      logic [15:0] vals [3];
      vals[0] = 16'd5; vals[1] = 16'd7; vals[2] = 16'd9;
      do_reset(); mon_b = 1'b0;
      load_sel = 2'd0; load_go = 1'b1; step(); load_go = 1'b0;
      n_chk++; if ({in_ready_a, busy_a} !== 2'b11) begin n_err++; $display("FAIL load3_ready got=%b exp=11", {in_ready_a, busy_a}); end
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = vals[i]; in_last = (i == 2);
         push(0, 1 + i, vals[i], i == 2);
         step();
      end
      in_valid = 1'b0; in_last = 1'b0;
      n_chk++; if (words_a !== 10'd3) begin n_err++; $display("FAIL load3_words got=%0d exp=3", words_a); end
      step();
      n_chk++; if ({busy_a, load_done_a, mem_we_a} !== 4'b0000) begin n_err++; $display("FAIL load3_idle got=%b exp=0000", {busy_a, load_done_a, mem_we_a}); end
      n_chk++; if (sb.size() != 0) begin n_err++; $display("FAIL load3_missing got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_toggle();
      int k = 0;
      do_reset(); mon_b = 1'b0;
      load_sel = 2'd1; load_go = 1'b1; step(); load_go = 1'b0;
      for (int j = 0; j < 8; j++) begin
         in_valid = (j % 2 == 0);
         in_data  = 16'(100 + k); in_last = (k == 3);
         if (in_valid) begin push(1, 1 + k, 16'(100 + k), k == 3); k++; end
         step();
         if (j % 2 == 1) begin
            n_chk++; if (mem_we_a !== 2'b00) begin n_err++; $display("FAIL toggle_gap_we j=%0d got=%b exp=00", j, mem_we_a); end
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      n_chk++; if (words_a !== 10'd4) begin n_err++; $display("FAIL toggle_words got=%0d exp=4", words_a); end
      n_chk++; if (sb.size() != 0) begin n_err++; $display("FAIL toggle_missing got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_overflow();
      do_reset(); mon_b = 1'b1;
      load_sel = 2'd0; load_go = 1'b1; step(); load_go = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_data = 16'(200 + i); in_last = (i == 9);
         if (i < 7) push(0, 1 + i, 16'(200 + i), 1'b0);
         step();
         if (i == 7) begin
            n_chk++; if ({mem_we_b, overflow_b, busy_b, load_done_b} !== 6'b000110) begin n_err++; $display("FAIL ovf_drain got=%b exp=000110", {mem_we_b, overflow_b, busy_b, load_done_b}); end
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      n_chk++; if ({load_done_b, mem_we_b} !== 4'b1000) begin n_err++; $display("FAIL ovf_done got=%b exp=1000", {load_done_b, mem_we_b}); end
      n_chk++; if (words_b !== 4'd7) begin n_err++; $display("FAIL ovf_words got=%0d exp=7", words_b); end
      step();
      n_chk++; if ({overflow_b, busy_b, load_done_b} !== 3'b100) begin n_err++; $display("FAIL ovf_sticky got=%b exp=100", {overflow_b, busy_b, load_done_b}); end
      n_chk++; if (sb.size() != 0) begin n_err++; $display("FAIL ovf_missing got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_run();
      do_reset(); mon_b = 1'b0;
      run_go = 1'b1;
      n_chk++; if (start_a !== 1'b0) begin n_err++; $display("FAIL run_early got=%b exp=0", start_a); end
      step(); run_go = 1'b0;
      n_chk++; if ({start_a, busy_a, in_ready_a} !== 3'b100) begin n_err++; $display("FAIL run_start got=%b exp=100", {start_a, busy_a, in_ready_a}); end
      load_sel = 2'd0; load_go = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF; step();
      load_go = 1'b0; step();
      n_chk++; if ({start_a, in_ready_a, mem_we_a} !== 4'b1000) begin n_err++; $display("FAIL run_load_ign got=%b exp=1000", {start_a, in_ready_a, mem_we_a}); end
      in_valid = 1'b0; run_stop = 1'b1; step(); run_stop = 1'b0;
      n_chk++; if (start_a !== 1'b0) begin n_err++; $display("FAIL run_stop got=%b exp=0", start_a); end
   endtask

   task automatic test_reset_midload();
      do_reset(); mon_b = 1'b0;
      load_sel = 2'd0; load_go = 1'b1; step(); load_go = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = 16'(300 + i); in_last = 1'b0;
         push(0, 1 + i, 16'(300 + i), 1'b0);
         step();
      end
      rst = 1'b1; in_data = 16'd302; step(); rst = 1'b0;
      n_chk++; if ({mem_we_a, in_ready_a, busy_a, load_done_a, overflow_a, start_a} !== 7'd0) begin n_err++; $display("FAIL mid_rst_flags got=%b exp=0000000", {mem_we_a, in_ready_a, busy_a, load_done_a, overflow_a, start_a}); end
      n_chk++; if ({mem_addr_a, mem_wdata_a, words_a} !== {9'd1, 16'd0, 10'd0}) begin n_err++; $display("FAIL mid_rst_vals got addr=%0d data=%0d words=%0d exp 1 0 0", mem_addr_a, mem_wdata_a, words_a); end
      step(); step(); step();
      in_valid = 1'b0;
      n_chk++; if (sb.size() != 0) begin n_err++; $display("FAIL mid_rst_missing got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_bad_sel();
      do_reset(); mon_b = 1'b1;
      load_sel = 2'd3; load_go = 1'b1; step(); load_go = 1'b0;
      n_chk++; if ({in_ready_b, busy_b} !== 2'b00) begin n_err++; $display("FAIL badsel_idle got=%b exp=00", {in_ready_b, busy_b}); end
      load_sel = 2'd1; load_go = 1'b1; run_go = 1'b1; step(); load_go = 1'b0; run_go = 1'b0;
      n_chk++; if ({busy_b, start_b} !== 2'b10) begin n_err++; $display("FAIL both_go got=%b exp=10", {busy_b, start_b}); end
      in_valid = 1'b1; in_data = 16'h0055; in_last = 1'b1;
      push(1, 1, 16'h0055, 1'b1);
      step(); in_valid = 1'b0; in_last = 1'b0; step();
      n_chk++; if ({start_b, busy_b} !== 2'b00) begin n_err++; $display("FAIL both_go_after got=%b exp=00", {start_b, busy_b}); end
      n_chk++; if (sb.size() != 0) begin n_err++; $display("FAIL badsel_missing got=%0d exp=0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_load3();
      test_toggle();
      test_overflow();
      test_run();
      test_reset_midload();
      test_bad_sel();
      step();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
